thee_mavg_filter_mc: RTL and testbench
======================================

// Module: thee_mavg_filter_mc
// PURPOSE
// Clocked, multi-channel moving-average low-pass filter. This is the discrete-time successor of the
// behavioural real-valued tap averager. Each accepted sample updates that channel's TAPS-deep history
// and running sum. The filter emits a saturated fixed-point average one cycle later.
// It sits after the ADC sample-capture stage and feeds the digital control loop.
// Transport is a valid/ready stream, with one sample per handshake and the channel tagged per sample.
// PARAMETERS
// DATA_W    16                  signed sample width, in and out (>=4)
// TAPS      4                   averaging depth; power of two, 2..64
// CHANNELS  2                   independent channels, 1..16
// CH_W      $clog2(CHANNELS)>1  channel index width (min 1)
// SAT_MAX   2**(DATA_W-1)-1     upper output clamp (signed); SAT_MIN <= SAT_MAX
// SAT_MIN   -2**(DATA_W-1)      lower output clamp (signed)
// PORTS
// clk        in   1       clock, all state on rising edge
// rst        in   1       synchronous reset, active-high
// flush      in   1       sync clear of all history/sums/pipeline (pulse)
// bypass     in   1       1: out = clamp(sample); history still updated
// in_valid   in   1       sample available
// in_ready   out  1       block can accept this cycle
// in_chan    in   CH_W    channel of sample; values >= CHANNELS are dropped
// in_data    in   DATA_W  signed sample
// out_valid  out  1       result held until taken
// out_ready  in   1       downstream accepts
// out_chan   out  CH_W    channel of result
// out_data   out  DATA_W  signed filtered result
// out_sat    out  1       1 if out_data was clamped
// BEHAVIOUR
// - Reset: all history = 0, sums = 0, write pointers = 0, out_valid=0, out_chan=0, out_data=0, out_sat=0.
//   in_ready=1 the cycle after reset deasserts. Reset overrides flush and handshakes.
// - in_ready = !out_valid | out_ready (1-entry output register, combinational ready, no bubble).
// - Accept = in_valid & in_ready & !flush. On accept with in_chan=c < CHANNELS:
//   old = hist[c][ptr[c]]; hist[c][ptr[c]] <= in_data; ptr[c] <= (ptr[c]==TAPS-1) ? 0 : ptr[c]+1;
//   sum[c] <= sum[c] + in_data - old. sum is signed, DATA_W+log2(TAPS) bits, and never overflows.
// - Result (same edge as accept, visible the next cycle; latency 1):
//   avg = (sum[c] + in_data - old) >>> log2(TAPS). This is an arithmetic shift, rounding toward -inf.
//   bypass=1: avg = in_data. out_data = clamp(avg, SAT_MIN, SAT_MAX); out_sat = (avg != out_data).
//   out_valid <= 1, out_chan <= c.
// - Invalid channel (in_chan >= CHANNELS): handshake completes (sample consumed) but no state changes
//   and no output is produced. If the output register drains the same cycle, out_valid <= 0.
// - Output drain: out_valid & out_ready & no new accept -> out_valid <= 0. Drain and accept in the
//   same cycle -> register reloads, out_valid stays 1.
// - Warm-up: history starts at 0, so the first TAPS-1 outputs per channel are zero-padded averages
//   (no count-based division).
// - Channels are fully independent. Interleaving in any order must give the same per-channel results
//   as running the channels separately.
// - flush=1 (rst=0): next cycle all history/sums/ptrs = 0 and out_valid=0, and any pending output is
//   discarded. in_valid is ignored that cycle and in_ready is forced to 0.
// - out_* are stable while out_valid & !out_ready (AXI-style hold).
// - bypass is sampled per accept, so a mode change mid-stream affects only subsequent samples.
// - History is implemented as registers or inferred RAM. One access per cycle suffices
//   (one sample per cycle).
// TESTING
// 1 TAPS=4,ch0: samples 100,100,100,100,100 -> out 25,50,75,100,100; out_chan=0, each 1 cycle after
//   accept.
// 2 Interleave ch0: 400,400 / ch1: -400,-400 alternating -> ch0 100,200; ch1 -100,-200; no cross-talk.
// 3 SAT_MAX=1000,SAT_MIN=-1000,bypass=1: in 32767 -> out 1000,out_sat=1; in -5 -> -5,out_sat=0.
// 4 Backpressure: out_ready=0 after first result -> in_ready=0, out_data held; out_ready=1 with
//   in_valid=1 -> drain+accept same cycle, no sample lost or duplicated.
// 5 Flush/reset mid-stream: ch0 history full of 100, pulse flush with in_valid=1 -> sample ignored,
//   out_valid=0; next sample 100 -> out 25. Repeat with rst -> identical.
// 6 Wrap/negative: ch0 samples -1 x5 -> out -1,-1,-1,-1,-1 (floor); in_chan=CHANNELS -> consumed,
//   no output.

Source files
------------

// File: rtl/thee_mavg_filter_mc.sv
// thee_mavg_filter_mc: multi-channel TAPS-deep moving-average filter with saturating valid/ready output
module thee_mavg_filter_mc #(
  parameter int DATA_W = 16,
  parameter int TAPS = 4,
  parameter int CHANNELS = 2,
  parameter int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int SAT_MAX = 2 ** (DATA_W - 1) - 1,
  parameter int SAT_MIN = -(2 ** (DATA_W - 1))
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              bypass,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_chan,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_chan,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat
);
  localparam int LT = $clog2(TAPS);
  localparam int SW = DATA_W + LT;
  localparam logic signed [SW-1:0] HI = SW'(SAT_MAX);
  localparam logic signed [SW-1:0] LO = SW'(SAT_MIN);
  logic signed [DATA_W-1:0] hist [CHANNELS][TAPS];
  logic signed [SW-1:0] sum [CHANNELS];
  logic [LT-1:0] ptr [CHANNELS];
  logic hit;
  logic signed [DATA_W-1:0] old;
  logic signed [SW-1:0] nsum, avg, res;
  always_comb begin
    in_ready = !flush && (!out_valid || out_ready);
    hit = in_valid && in_ready && ({1'b0, in_chan} < (CH_W + 1)'(CHANNELS));
    old = hist[in_chan][ptr[in_chan]];
    nsum = sum[in_chan] + SW'($signed(in_data)) - SW'(old);
    avg = bypass ? SW'($signed(in_data)) : nsum >>> LT;
    res = (avg > HI) ? HI : (avg < LO) ? LO : avg;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sum[i] <= '0;
        ptr[i] <= '0;
        for (int j = 0; j < TAPS; j++) hist[i][j] <= '0;
      end
      out_valid <= 1'b0;
      if (rst) begin
        out_chan <= '0;
        out_data <= '0;
        out_sat <= 1'b0;
      end
    end else if (hit) begin
      hist[in_chan][ptr[in_chan]] <= in_data;
      ptr[in_chan] <= ptr[in_chan] + 1'b1;
      sum[in_chan] <= nsum;
      out_valid <= 1'b1;
      out_chan <= in_chan;
      out_data <= res[DATA_W-1:0];
      out_sat <= avg != res;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_thee_mavg_filter_mc.sv
// tb_thee_mavg_filter_mc: directed checks of averaging, interleave, saturation, backpressure, flush/reset
module tb_thee_mavg_filter_mc;
  logic clk = 0, rst = 1, flush = 0, bypass = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, out_sat;
  logic [1:0] in_chan = 0, out_chan;
  logic [15:0] in_data = 0, out_data;
  int checks = 0, errors = 0;
  thee_mavg_filter_mc #(.DATA_W(16), .TAPS(4), .CHANNELS(3), .SAT_MAX(1000), .SAT_MIN(-1000)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bypass(bypass), .in_valid(in_valid), .in_ready(in_ready),
    .in_chan(in_chan), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_chan(out_chan), .out_data(out_data), .out_sat(out_sat));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int ch, input int d, input int exp, input string tag);
    in_chan = 2'(ch);
    in_data = 16'(d);
    in_valid = 1;
    step();
    in_valid = 0;
    chk({tag, " valid"}, int'(out_valid), 1);
    chk({tag, " chan"}, int'(out_chan), ch);
    chk({tag, " data"}, int'($signed(out_data)), exp);
  endtask
  task automatic do_flush();
    flush = 1;
    step();
    flush = 0;
  endtask
  initial begin
    step();
    step();
    rst = 0;
    step();
    chk("rst valid", int'(out_valid), 0);
    chk("rst data", int'($signed(out_data)), 0);
    chk("rst sat", int'(out_sat), 0);
    chk("rst ready", int'(in_ready), 1);
    send(0, 100, 25, "t1a");
    send(0, 100, 50, "t1b");
    send(0, 100, 75, "t1c");
    send(0, 100, 100, "t1d");
    send(0, 100, 100, "t1e");
    do_flush();
    send(0, 400, 100, "t2a");
    send(1, -400, -100, "t2b");
    send(0, 400, 200, "t2c");
    send(1, -400, -200, "t2d");
    bypass = 1;
    send(2, 32767, 1000, "t3a");
    chk("t3a sat", int'(out_sat), 1);
    send(2, -5, -5, "t3b");
    chk("t3b sat", int'(out_sat), 0);
    bypass = 0;
    do_flush();
    out_ready = 0;
    send(0, 40, 10, "t4a");
    chk("t4 ready low", int'(in_ready), 0);
    in_data = 80;
    in_valid = 1;
    step();
    chk("t4 hold data", int'($signed(out_data)), 10);
    chk("t4 hold valid", int'(out_valid), 1);
    out_ready = 1;
    step();
    in_valid = 0;
    chk("t4 reload data", int'($signed(out_data)), 30);
    chk("t4 reload valid", int'(out_valid), 1);
    step();
    chk("t4 drained", int'(out_valid), 0);
    send(0, 0, 30, "t4 no dup");
    do_flush();
    for (int i = 0; i < 4; i++) send(0, 100, 25 * (i + 1), "t5 fill");
    flush = 1;
    in_data = 100;
    in_valid = 1;
    #1;
    chk("t5 flush ready", int'(in_ready), 0);
    step();
    flush = 0;
    in_valid = 0;
    chk("t5 flush valid", int'(out_valid), 0);
    send(0, 100, 25, "t5 after flush");
    for (int i = 1; i < 4; i++) send(0, 100, 25 * (i + 1), "t5 refill");
    rst = 1;
    in_valid = 1;
    step();
    rst = 0;
    in_valid = 0;
    chk("t5 rst valid", int'(out_valid), 0);
    send(0, 100, 25, "t5 after rst");
    do_flush();
    for (int i = 0; i < 5; i++) send(0, -1, -1, "t6 neg");
    in_chan = 3;
    in_data = 400;
    in_valid = 1;
    #1;
    chk("t6 bad ready", int'(in_ready), 1);
    step();
    in_valid = 0;
    chk("t6 bad dropped", int'(out_valid), 0);
    send(0, -5, -2, "t6 after bad");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
